// File: rtl/rvc_fetch_if.sv
// Bundle between the fetch aligner, the I-cache and the core front end.
// Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready;
// a word transfers where ic_req && !ic_stall. Neither producer may retract an offer
// except on redirect or reset.
interface rvc_fetch_if;
  logic        ic_req;
  logic [29:0] ic_addr;
  logic        ic_stall;
  logic [31:0] ic_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_c;
  logic        inst_ready;

  modport master (
    output ic_req, ic_addr, inst_valid, inst, inst_pc, inst_c,
    input  ic_stall, ic_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  ic_req, ic_addr, inst_valid, inst, inst_pc, inst_c,
    output ic_stall, ic_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// Halfword fetch aligner: buffers I-cache words as halfwords and hands the core one
// whole RVC or RV32 instruction per handshake, including word-straddling ones.
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  rvc_fetch_if.master   bus,
  output logic          dbg_running
);

  typedef enum logic {ST_RESET = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] hw_buf_q [4];
  logic [15:0] hw_buf_d [4];
  logic [15:0] shifted  [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [29:0] fetch_addr_q, fetch_addr_d;
  logic        skip_lo_q, skip_lo_d;

  logic        running;
  logic        compressed;
  logic        inst_valid;
  logic        ic_req;
  logic        accept;
  logic [1:0]  used;
  logic [2:0]  base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      for (int i = 0; i < 4; i++) hw_buf_q[i] <= 16'h0;
      cnt_q        <= 3'd0;
      head_pc_q    <= RESET_PC & ~32'h1;
      fetch_addr_q <= RESET_PC[31:2];
      skip_lo_q    <= RESET_PC[1];
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < 4; i++) hw_buf_q[i] <= hw_buf_d[i];
      cnt_q        <= cnt_d;
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
    end
  end

  // Run state leaves reset on the first clock after release and stays there.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RESET) state_d = ST_RUN;
  end

  always_comb begin
    running    = (state_q == ST_RUN);
    compressed = (hw_buf_q[0][1:0] != 2'b11);
    inst_valid = compressed ? (cnt_q != 3'd0) : (cnt_q >= 3'd2);
    ic_req     = running && !bus.redirect && (cnt_q <= 3'd2);
    accept     = ic_req && !bus.ic_stall;
    used       = (inst_valid && bus.inst_ready) ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    base       = cnt_q - {1'b0, used};

    for (int i = 0; i < 4; i++) shifted[i] = 16'h0;
    case (used)
      2'd1: begin
        shifted[0] = hw_buf_q[1];
        shifted[1] = hw_buf_q[2];
        shifted[2] = hw_buf_q[3];
      end
      2'd2: begin
        shifted[0] = hw_buf_q[2];
        shifted[1] = hw_buf_q[3];
      end
      default: begin
        for (int i = 0; i < 4; i++) shifted[i] = hw_buf_q[i];
      end
    endcase

    for (int i = 0; i < 4; i++) hw_buf_d[i] = shifted[i];
    cnt_d        = base;
    head_pc_d    = head_pc_q + {29'b0, used, 1'b0};
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;

    // Appended halfwords land right after the survivors; cnt<=2 at accept keeps base+1<=3.
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) == base)
          hw_buf_d[i] = skip_lo_q ? bus.ic_rdata[31:16] : bus.ic_rdata[15:0];
        if (!skip_lo_q && (3'(i) == base + 3'd1))
          hw_buf_d[i] = bus.ic_rdata[31:16];
      end
      cnt_d        = base + (skip_lo_q ? 3'd1 : 3'd2);
      fetch_addr_d = fetch_addr_q + 30'd1;
      skip_lo_d    = 1'b0;
    end

    if (bus.redirect) begin
      for (int i = 0; i < 4; i++) hw_buf_d[i] = hw_buf_q[i];
      cnt_d        = 3'd0;
      head_pc_d    = bus.redirect_pc & ~32'h1;
      fetch_addr_d = bus.redirect_pc[31:2];
      skip_lo_d    = bus.redirect_pc[1];
    end
  end

  assign bus.ic_req     = ic_req;
  assign bus.ic_addr    = fetch_addr_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = compressed ? {16'h0, hw_buf_q[0]} : {hw_buf_q[1], hw_buf_q[0]};
  assign bus.inst_pc    = head_pc_q;
  assign bus.inst_c     = compressed;
  assign dbg_running    = running;

endmodule
